// File: rtl/sprite_pkg.sv
// Shared constants and state type for the sprite renderer and the movement controllers.
package sprite_pkg;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] DEF_PLAYER_COLOUR = 3'b111;
    localparam logic [2:0] DEF_ENEMY_COLOUR  = 3'b100;
    localparam logic [2:0] DEF_BG_COLOUR     = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        ERASE_P,
        DRAW_P,
        ERASE_E,
        DRAW_E,
        FINISH
    } state_t;
endpackage

// File: rtl/sprite_scan.sv
// Row-major box scanner: dx runs fastest, dy slowest; wraps to 0,0 after the last pixel
// so consecutive phases of different sizes chain with no gap cycles.
module sprite_scan (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] size,
    input  logic       start,
    output logic [2:0] dx,
    output logic [2:0] dy,
    output logic       last
);
    logic row_end;

    // End-of-row and end-of-box detection for the current phase size.
    always_comb begin
        row_end = (dx == size - 3'd1);
        last    = row_end && (dy == size - 3'd1);
    end

    // Counter pair; held at the origin while start is high.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            dx <= 3'd0;
            dy <= 3'd0;
        end else if (last) begin
            dx <= 3'd0;
            dy <= 3'd0;
        end else if (row_end) begin
            dx <= 3'd0;
            dy <= dy + 3'd1;
        end else begin
            dx <= dx + 3'd1;
        end
    end
endmodule

// File: rtl/sprite_renderer.sv
// Erases and redraws the player and enemy boxes, one registered pixel per clock.
//
// state   | meaning
// IDLE    | waiting for update or pending request
// ERASE_P | painting background over the previously drawn player box
// DRAW_P  | painting the player box at the snapshot position
// ERASE_E | painting background over the previously drawn enemy box
// DRAW_E  | painting the enemy box at the snapshot position/size
// FINISH  | pass complete; done pulse and busy release follow
module sprite_renderer #(
    parameter int         PLAYER_SIZE   = 4,
    parameter logic [2:0] PLAYER_COLOUR = sprite_pkg::DEF_PLAYER_COLOUR,
    parameter logic [2:0] ENEMY_COLOUR  = sprite_pkg::DEF_ENEMY_COLOUR,
    parameter logic [2:0] BG_COLOUR     = sprite_pkg::DEF_BG_COLOUR,
    parameter int         SCREEN_W      = sprite_pkg::SCREEN_W,
    parameter int         SCREEN_H      = sprite_pkg::SCREEN_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       update,
    input  logic [7:0] player_x,
    input  logic [6:0] player_y,
    input  logic [7:0] enemy_x,
    input  logic [6:0] enemy_y,
    input  logic [2:0] enemy_size,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    import sprite_pkg::*;

    localparam logic [2:0] P_SIZE = 3'(PLAYER_SIZE);

    state_t         state;
    logic [X_W-1:0] snap_px, snap_ex, old_px, old_ex, base_x;
    logic [Y_W-1:0] snap_py, snap_ey, old_py, old_ey, base_y;
    logic [2:0]     snap_es, old_es, scan_size, phase_colour;
    logic           pending, player_valid, enemy_valid, in_phase;
    logic [2:0]     dx, dy;
    logic           scan_last, scan_start;
    logic [X_W:0]   pix_x;
    logic [Y_W:0]   pix_y;

    sprite_scan u_scan (
        .clk   (clk),
        .reset (reset),
        .size  (scan_size),
        .start (scan_start),
        .dx    (dx),
        .dy    (dy),
        .last  (scan_last)
    );

    // Select box origin, size and colour for the active phase; one extra bit avoids wrap.
    always_comb begin
        scan_size    = P_SIZE;
        base_x       = old_px;
        base_y       = old_py;
        phase_colour = BG_COLOUR;
        in_phase     = 1'b1;
        case (state)
            ERASE_P: begin end
            DRAW_P: begin
                base_x       = snap_px;
                base_y       = snap_py;
                phase_colour = PLAYER_COLOUR;
            end
            ERASE_E: begin
                scan_size = old_es;
                base_x    = old_ex;
                base_y    = old_ey;
            end
            DRAW_E: begin
                scan_size    = snap_es;
                base_x       = snap_ex;
                base_y       = snap_ey;
                phase_colour = ENEMY_COLOUR;
            end
            default: in_phase = 1'b0;
        endcase
        scan_start = (state == IDLE) || (state == FINISH);
        pix_x      = {1'b0, base_x} + {6'd0, dx};
        pix_y      = {1'b0, base_y} + {5'd0, dy};
    end

    // Sequencer with registered pixel outputs and erase bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= 1'b0;
            player_valid <= 1'b0;
            enemy_valid  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            plot         <= 1'b0;
            x            <= '0;
            y            <= '0;
            colour       <= BG_COLOUR;
        end else begin
            done <= 1'b0;
            plot <= in_phase && (pix_x < (X_W+1)'(SCREEN_W)) && (pix_y < (Y_W+1)'(SCREEN_H));
            if (in_phase) begin
                x      <= pix_x[X_W-1:0];
                y      <= pix_y[Y_W-1:0];
                colour <= phase_colour;
            end
            if (state != IDLE && update) pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (update || pending) begin
                        snap_px <= player_x;
                        snap_py <= player_y;
                        snap_ex <= enemy_x;
                        snap_ey <= enemy_y;
                        snap_es <= enemy_size;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                        state   <= player_valid ? ERASE_P : DRAW_P;
                    end
                end
                ERASE_P: if (scan_last) state <= DRAW_P;
                DRAW_P: begin
                    if (scan_last) begin
                        old_px       <= snap_px;
                        old_py       <= snap_py;
                        player_valid <= 1'b1;
                        if (enemy_valid)          state <= ERASE_E;
                        else if (snap_es != 3'd0) state <= DRAW_E;
                        else                      state <= FINISH;
                    end
                end
                ERASE_E: if (scan_last) state <= (snap_es != 3'd0) ? DRAW_E : FINISH;
                DRAW_E: begin
                    if (scan_last) begin
                        old_ex      <= snap_ex;
                        old_ey      <= snap_ey;
                        old_es      <= snap_es;
                        enemy_valid <= 1'b1;
                        state       <= FINISH;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (snap_es == 3'd0) enemy_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_renderer.sv
// Self-checking bench: a box-level reference model predicts the ordered pixel stream and
// the pass length for each render pass.
module tb_sprite_renderer;
    logic       clk = 1'b0;
    logic       reset, update;
    logic [7:0] player_x, enemy_x, x;
    logic [6:0] player_y, enemy_y, y;
    logic [2:0] enemy_size, colour;
    logic       plot, busy, done;

    typedef struct packed {
        logic [8:0] px;
        logic [7:0] py;
        logic [2:0] c;
    } pix_t;

    pix_t exp_q[$];
    pix_t act_q[$];
    int   n_cmp = 0, n_fail = 0;
    int   exp_cycles;
    bit   m_pv, m_ev;
    int   m_px, m_py, m_ex, m_ey, m_es;
    logic [7:0] nxt_px, nxt_ex;
    logic [6:0] nxt_py, nxt_ey;
    logic [2:0] nxt_es;

    sprite_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .update     (update),
        .player_x   (player_x),
        .player_y   (player_y),
        .enemy_x    (enemy_x),
        .enemy_y    (enemy_y),
        .enemy_size (enemy_size),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One square of S*S scan cycles; only on-screen pixels are visible.
    function automatic void model_box(int bx, int by, int s, logic [2:0] col);
        for (int j = 0; j < s; j++)
            for (int i = 0; i < s; i++)
                if (bx + i < 160 && by + j < 120)
                    exp_q.push_back({9'(bx + i), 8'(by + j), col});
        exp_cycles += s * s;
    endfunction

    function automatic void model_pass();
        exp_q.delete();
        exp_cycles = 0;
        if (m_pv) model_box(m_px, m_py, 4, 3'b000);
        model_box(int'(player_x), int'(player_y), 4, 3'b111);
        m_pv = 1; m_px = int'(player_x); m_py = int'(player_y);
        if (m_ev) model_box(m_ex, m_ey, m_es, 3'b000);
        if (enemy_size != 0) begin
            model_box(int'(enemy_x), int'(enemy_y), int'(enemy_size), 3'b100);
            m_ev = 1; m_ex = int'(enemy_x); m_ey = int'(enemy_y); m_es = int'(enemy_size);
        end else begin
            m_ev = 0;
        end
    endfunction

    task automatic set_in(input int px, input int py, input int ex, input int ey, input int es);
        player_x = 8'(px); player_y = 7'(py);
        enemy_x = 8'(ex); enemy_y = 7'(ey); enemy_size = 3'(es);
    endtask

    // drive=0: the pass is expected to start on its own from a pending request.
    task automatic run_pass(input bit drive, input int u1, input int u2);
        int got = 0;
        if (drive) begin
            @(negedge clk);
            update = 1'b1;
        end
        @(posedge clk);
        model_pass();
        #1 update = 1'b0;
        act_q.delete();
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) check("busy_in_pass", busy, 1);
            if (plot) act_q.push_back({1'b0, x, 1'b0, y, colour});
            if (done) begin
                got = c;
                break;
            end
            update = (c == u1 || c == u2);
            if (update) begin
                player_x = nxt_px; player_y = nxt_py;
                enemy_x = nxt_ex; enemy_y = nxt_ey; enemy_size = nxt_es;
            end
        end
        update = 1'b0;
        check("done_cycle", got, exp_cycles + 2);
        check("busy_at_done", busy, 0);
        check("plot_count", act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            check("pixel", act_q[i], exp_q[i]);
    endtask

    task automatic check_idle(input int n);
        int plots = 0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        repeat (n) begin
            @(negedge clk);
            if (plot) plots++;
        end
        check("idle_plots", plots, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int whites;
        reset = 1'b1; update = 1'b0;
        set_in(0, 0, 0, 0, 0);
        m_pv = 0; m_ev = 0; m_px = 0; m_py = 0; m_ex = 0; m_ey = 0; m_es = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        set_in(80, 100, 10, 20, 3);
        run_pass(1, 0, 0);
        check_idle(3);
        set_in(81, 100, 10, 20, 3);
        run_pass(1, 0, 0);
        check_idle(3);

        set_in(158, 50, 10, 20, 3);
        run_pass(1, 0, 0);
        whites = 0;
        foreach (act_q[i]) if (act_q[i].c == 3'b111) whites++;
        check("clip_white_count", whites, 8);
        check_idle(3);

        set_in(20, 30, 10, 20, 3);
        nxt_px = 8'd25; nxt_py = 7'd35; nxt_ex = 8'd40; nxt_ey = 7'd40; nxt_es = 3'd2;
        run_pass(1, 3, 10);
        run_pass(0, 0, 0);
        check_idle(5);

        set_in(30, 30, 50, 60, 3);
        run_pass(1, 0, 0);
        set_in(31, 30, 50, 60, 0);
        run_pass(1, 0, 0);
        set_in(32, 30, 50, 60, 0);
        run_pass(1, 0, 0);
        check_idle(3);

        set_in(60, 40, 100, 80, 2);
        @(negedge clk);
        update = 1'b1;
        @(posedge clk);
        #1 update = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_draw_colour", colour, 3'b111);
        reset = 1'b1; update = 1'b1;
        @(negedge clk);
        check("abort_plot", plot, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b0; update = 1'b0;
        m_pv = 0; m_ev = 0;
        check_idle(6);
        set_in(61, 40, 100, 80, 2);
        run_pass(1, 0, 0);

        for (int k = 0; k < 10; k++) begin
            set_in(int'($urandom_range(0, 200)), int'($urandom_range(0, 127)),
                   int'($urandom_range(0, 200)), int'($urandom_range(0, 127)),
                   int'($urandom_range(0, 7)));
            run_pass(1, 0, 0);
        end
        check_idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
